serial_slice_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder/subtractor: processes SLICE bits per clock, LSB slice first,

---
 rtl/adder_pkg.sv | 12 +
 rtl/serial_slice_adder_if.sv | 26 ++
 rtl/full_adder.sv | 13 +
 rtl/slice_ripple_adder.sv | 31 +++
 rtl/serial_slice_adder.sv | 126 ++++++++++++
 tb/tb_serial_slice_adder.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/adder_pkg.sv
// Shared types for the serial slice adder.
//   state_e : control FSM states
//   cnt_w() : slice counter width for N slices (never below 1 bit)
package adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_slice_adder_if.sv
// Operand/result handshake bundle for serial_slice_adder.
//   master : operand producer + result consumer (drives in_valid/a/b/cin/sub/out_ready)
//   slave  : the adder (drives in_ready/out_valid/s/cout/ovf)
interface serial_slice_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell.
//   a, b, ci : addends and carry in
//   s, co    : sum and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/slice_ripple_adder.sv
// Combinational SLICE-bit ripple adder built from full_adder cells.
//   a, b  : slice operands      ci    : carry into bit 0
//   sum   : slice sum           co    : carry out of top bit
//   c_top : carry into the top bit (feeds signed-overflow detection)
module slice_ripple_adder #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] sum,
  output logic             co,
  output logic             c_top
);
  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign co    = c[SLICE];
  assign c_top = c[SLICE-1];
endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, SLICE bits per clock, LSB slice first.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of serial_slice_adder_if (operands in, result out)
// Accept in IDLE, N=WIDTH/SLICE slice cycles in RUN, hold result in DONE until taken.
module serial_slice_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_slice_adder_if.slave   bus
);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("serial_slice_adder: SLICE must be >= 1 and divide WIDTH");
  end

  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_w(N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_ctop;
  int               idx;

  assign idx  = int'(cnt_q) * SLICE;
  assign sl_a = SLICE'(a_q >> idx);
  assign sl_b = SLICE'(b_q >> idx);

  slice_ripple_adder #(.SLICE(SLICE)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .ci    (carry_q),
    .sum   (sl_s),
    .co    (sl_co),
    .c_top (sl_ctop)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        // Subtract folds into add: invert B here, force carry-in to 1.
        a_d        = bus.a;
        b_d        = bus.b ^ {WIDTH{bus.sub}};
        carry_d    = bus.sub ? 1'b1 : bus.cin;
        cnt_d      = '0;
        in_ready_d = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        s_d[idx +: SLICE] = sl_s;
        carry_d           = sl_co;
        if (cnt_q == CW'(N - 1)) begin
          cout_d      = sl_co;
          ovf_d       = sl_co ^ sl_ctop;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: four WIDTH=8 instances, SLICE = 1,2,4,8 (index k -> SLICE=1<<k).
// Expected results come from an 9-bit integer reference model, queued at drive time.
module tb_serial_slice_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_i [4];
  logic       out_ready_i[4];
  logic       cin_i      [4];
  logic       sub_i      [4];
  logic [7:0] a_i        [4];
  logic [7:0] b_i        [4];
  logic       in_ready_o [4];
  logic       out_valid_o[4];
  logic       cout_o     [4];
  logic       ovf_o      [4];
  logic [7:0] s_o        [4];

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_slice_adder_if #(.WIDTH(8)) bus ();
    assign bus.in_valid  = in_valid_i[g];
    assign bus.out_ready = out_ready_i[g];
    assign bus.a         = a_i[g];
    assign bus.b         = b_i[g];
    assign bus.cin       = cin_i[g];
    assign bus.sub       = sub_i[g];
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;
    assign s_o[g]         = bus.s;
    assign cout_o[g]      = bus.cout;
    assign ovf_o[g]       = bus.ovf;

    serial_slice_adder #(.WIDTH(8), .SLICE(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic sb);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] f;
    bb     = sb ? ~b : b;
    f      = {1'b0, a} + {1'b0, bb} + {8'd0, (sb ? 1'b1 : ci)};
    e.s    = f[7:0];
    e.cout = f[8];
    e.ovf  = (a[7] == bb[7]) && (f[7] != a[7]);
    return e;
  endfunction

  // One full transaction on instance k; hold = cycles to stall out_ready in DONE.
  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb, input int hold);
    exp_t e;
    int   lat;
    int   n;
    n = 8 >> k;
    sb_q.push_back(model(av, bv, ci, sb));
    chk("in_ready_idle", 32'(in_ready_o[k]), 32'd1);
    a_i[k] = av; b_i[k] = bv; cin_i[k] = ci; sub_i[k] = sb;
    in_valid_i[k]  = 1'b1;
    out_ready_i[k] = (hold == 0);
    tick;
    // Scramble operands after accept: the result must not follow them.
    in_valid_i[k] = 1'b0;
    a_i[k] = ~av; b_i[k] = av ^ bv; cin_i[k] = ~ci; sub_i[k] = ~sb;
    if (n > 1) chk("in_ready_run", 32'(in_ready_o[k]), 32'd0);
    lat = 0;
    do begin
      if (!out_valid_o[k]) begin
        tick;
        lat++;
      end
    end while (!out_valid_o[k] && lat < 40);
    if (lat == 0) begin
      tick;
      lat++;
    end
    chk("latency", 32'(lat), 32'(n));
    e = sb_q.pop_front();
    chk("s",    32'(s_o[k]),    32'(e.s));
    chk("cout", 32'(cout_o[k]), 32'(e.cout));
    chk("ovf",  32'(ovf_o[k]),  32'(e.ovf));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", 32'(out_valid_o[k]), 32'd1);
      chk("hold_s",     32'({s_o[k], cout_o[k], ovf_o[k]}), 32'({e.s, e.cout, e.ovf}));
      chk("hold_ready", 32'(in_ready_o[k]), 32'd0);
    end
    out_ready_i[k] = 1'b1;
    tick;
    out_ready_i[k] = 1'b0;
    chk("drain_valid", 32'(out_valid_o[k]), 32'd0);
    chk("drain_ready", 32'(in_ready_o[k]), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid_i[k] = 1'b0; out_ready_i[k] = 1'b0; cin_i[k] = 1'b0; sub_i[k] = 1'b0;
      a_i[k] = 8'h00; b_i[k] = 8'h00;
    end
    tick;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready",  32'(in_ready_o[k]),  32'd1);
      chk("rst_out_valid", 32'(out_valid_o[k]), 32'd0);
      chk("rst_s",         32'(s_o[k]),         32'd0);
      chk("rst_cout",      32'(cout_o[k]),      32'd0);
      chk("rst_ovf",       32'(ovf_o[k]),       32'd0);
    end
    rst_n = 1'b1;
    tick;

    // SLICE=2 directed
    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(1, 8'h07, 8'h05, 1'b1, 1'b1, 0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 0);
    run_op(1, 8'h80, 8'hFF, 1'b0, 1'b0, 0);
    run_op(1, 8'h12, 8'h34, 1'b1, 1'b0, 10);
    run_op(1, 8'hA5, 8'h5A, 1'b0, 1'b1, 0);

    // Reset while slice 2 is pending: no result may appear.
    a_i[1] = 8'h5A; b_i[1] = 8'h33; cin_i[1] = 1'b0; sub_i[1] = 1'b0;
    in_valid_i[1] = 1'b1;
    out_ready_i[1] = 1'b1;
    tick;
    in_valid_i[1] = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_valid", 32'(out_valid_o[1]), 32'd0);
    chk("abort_ready", 32'(in_ready_o[1]),  32'd1);
    chk("abort_s",     32'(s_o[1]),         32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_quiet", 32'(out_valid_o[1]), 32'd0);
    end
    out_ready_i[1] = 1'b0;
    run_op(1, 8'h5A, 8'h33, 1'b0, 1'b0, 0);

    // SLICE=8 single-cycle
    run_op(3, 8'h3C, 8'hC3, 1'b1, 1'b0, 0);

    // Random sweep on every slice width
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 40; i++) begin
        run_op(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
